// File: rtl/echo_pkg.sv
// Shared types and 50 MHz timing defaults for the Echo module drivers
// (sonar ranger and servo).
package echo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    DONE,
    HOLDOFF
  } sonar_state_t;

  localparam logic [7:0] DIST_INVALID = 8'hFF;

  localparam int DEF_TRIG_CYCLES    = 500;
  localparam int DEF_CLKS_PER_UNIT  = 2900;
  localparam int DEF_RISE_TIMEOUT   = 1_500_000;
  localparam int DEF_HOLDOFF_CYCLES = 3_000_000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sonar_driver.sv
// HC-SR04 ranger driver: trigger pulse, echo width timing, 8-bit distance code.
// Optional SONAR_FILTER_EN averages each new result with the previous distance.
module sonar_driver
  import echo_pkg::*;
#(
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int CLKS_PER_UNIT  = DEF_CLKS_PER_UNIT,
  parameter int RISE_TIMEOUT   = DEF_RISE_TIMEOUT,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       measure,
  input  logic       echo,
  output logic       trig,
  output logic       ready,
  output logic [7:0] distance,
  output logic       busy
);

  localparam int CNT_W = $clog2(max3(TRIG_CYCLES, RISE_TIMEOUT, HOLDOFF_CYCLES));
  localparam int PRE_W = $clog2(CLKS_PER_UNIT);

  sonar_state_t     state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [PRE_W-1:0] presc, presc_nx;
  logic [7:0]       units, units_nx;
  logic [7:0]       result, dist_new;
  logic             pending, pending_nx;
  logic             echo_s;

  sync_2ff u_echo_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (echo),
    .q     (echo_s)
  );

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    presc_nx   = presc;
    units_nx   = units;
    pending_nx = pending;
    result     = units;
    case (state)
      IDLE: begin
        if (measure) begin
          state_nx = TRIG;
          cnt_nx   = '0;
        end
      end
      TRIG: begin
        if (cnt == CNT_W'(TRIG_CYCLES - 1)) begin
          state_nx = WAIT_RISE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      WAIT_RISE: begin
        if (echo_s) begin
          // The rise cycle itself is echo-high time, so it is counted here
          // (prescaler starts at 1); assumes CLKS_PER_UNIT >= 2.
          state_nx = MEASURE;
          presc_nx = PRE_W'(1);
          units_nx = '0;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(RISE_TIMEOUT - 1)) begin
          state_nx = DONE;
          result   = DIST_INVALID;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      MEASURE: begin
        if (!echo_s) begin
          state_nx = DONE;
        end else begin
          // Once saturated, the shared counter times how long echo stays stuck.
          if (units == DIST_INVALID) begin
            if (cnt == CNT_W'(RISE_TIMEOUT - 1)) begin
              state_nx = DONE;
              result   = DIST_INVALID;
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end
          if (presc == PRE_W'(CLKS_PER_UNIT - 1)) begin
            presc_nx = '0;
            if (units != DIST_INVALID) units_nx = units + 8'd1;
          end else begin
            presc_nx = presc + PRE_W'(1);
          end
        end
      end
      DONE: begin
        state_nx = HOLDOFF;
        cnt_nx   = '0;
      end
      HOLDOFF: begin
        if (cnt == CNT_W'(HOLDOFF_CYCLES - 1)) begin
          cnt_nx = '0;
          if (pending || measure) begin
            state_nx   = TRIG;
            pending_nx = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
          if (measure) pending_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef SONAR_FILTER_EN
  logic       first_done;
  logic [8:0] avg_sum;

  always_comb begin
    avg_sum = {1'b0, distance} + {1'b0, result} + 9'd1;
    if (!first_done || result == DIST_INVALID) dist_new = result;
    else dist_new = avg_sum[8:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) first_done <= 1'b0;
    else if (state_nx == DONE) first_done <= 1'b1;
  end
`else
  assign dist_new = result;
`endif

  // Outputs are registered from next-state so trig reaches the sensor glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      presc    <= '0;
      units    <= '0;
      pending  <= 1'b0;
      trig     <= 1'b0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      distance <= 8'h00;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      presc   <= presc_nx;
      units   <= units_nx;
      pending <= pending_nx;
      trig    <= (state_nx == TRIG);
      ready   <= (state_nx == DONE);
      busy    <= (state_nx != IDLE);
      if (state_nx == DONE) distance <= dist_new;
    end
  end

endmodule

// File: tb/tb_sonar_driver.sv
// Bench for sonar_driver with short timing parameters; honours SONAR_FILTER_EN.
module tb_sonar_driver;

  localparam int TRIG_CYCLES    = 5;
  localparam int CLKS_PER_UNIT  = 4;
  localparam int RISE_TIMEOUT   = 100;
  localparam int HOLDOFF_CYCLES = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       measure;
  logic       echo;
  logic       trig;
  logic       ready;
  logic [7:0] distance;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int ready_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] model_dist  = 8'h00;
  bit         model_first = 1'b1;
  logic [7:0] last_exp    = 8'h00;

  sonar_driver #(
    .TRIG_CYCLES    (TRIG_CYCLES),
    .CLKS_PER_UNIT  (CLKS_PER_UNIT),
    .RISE_TIMEOUT   (RISE_TIMEOUT),
    .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .measure  (measure),
    .echo     (echo),
    .trig     (trig),
    .ready    (ready),
    .distance (distance),
    .busy     (busy)
  );

  // Clock / reset-independent monitors
  always #5 clk = ~clk;

  always @(negedge clk) if (ready) ready_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference model: distance code from echo width in clock cycles (0 = no echo).
  function automatic logic [7:0] ref_raw(input int width);
    int u;
    if (width == 0) return 8'hFF;
    u = width / CLKS_PER_UNIT;
    if (u >= 255) return 8'hFF;
    return 8'(u);
  endfunction

  task automatic predict(input int width);
    logic [7:0] raw;
    logic [7:0] d;
    raw = ref_raw(width);
`ifdef SONAR_FILTER_EN
    if (model_first || raw == 8'hFF) d = raw;
    else d = 8'((int'(model_dist) + int'(raw) + 1) / 2);
`else
    d = raw;
`endif
    model_first = 1'b0;
    model_dist  = d;
    exp_q.push_back(d);
  endtask

  // Driver tasks
  task automatic drive_echo(input int gap, input int width, input bit mid);
    if (width > 0) begin
      repeat (gap) @(negedge clk);
      echo = 1'b1;
      for (int i = 0; i < width; i++) begin
        measure = mid && (i == width / 2);
        @(negedge clk);
      end
      echo    = 1'b0;
      measure = 1'b0;
    end
  endtask

  task automatic wait_trig(input string tag, output int lat);
    int n;
    lat = 0;
    while (!trig && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " trig_seen"}, trig, 1);
    n = 0;
    while (trig && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({tag, " trig_len"}, n, TRIG_CYCLES);
  endtask

  task automatic wait_ready(input string tag, output int lat);
    lat = 0;
    while (!ready && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " ready_seen"}, ready, 1);
    if (ready) begin
      if (exp_q.size() > 0) begin
        last_exp = exp_q.pop_front();
        check({tag, " distance"}, distance, last_exp);
      end else begin
        check({tag, " unexpected_ready"}, 1, 0);
      end
    end
  endtask

  task automatic check_holdoff(input string tag);
    int h;
    @(negedge clk);
    check({tag, " ready_pulse"}, ready, 0);
    h = 0;
    while (busy && h < 200) begin
      h++;
      @(negedge clk);
    end
    check({tag, " holdoff_len"}, h, HOLDOFF_CYCLES);
    check({tag, " distance_held"}, distance, last_exp);
  endtask

  task automatic measure_once(input string tag, input int gap, input int width);
    int lat;
    int r0;
    r0 = ready_cnt;
    predict(width);
    measure = 1'b1;
    @(negedge clk);
    measure = 1'b0;
    check({tag, " busy"}, busy, 1);
    wait_trig(tag, lat);
    check({tag, " trig_lat"}, lat, 0);
    fork
      drive_echo(gap, width, 1'b0);
      begin
        int rl;
        wait_ready(tag, rl);
        if (width == 0) check({tag, " timeout_lat"}, rl, RISE_TIMEOUT);
        check_holdoff(tag);
      end
    join
    repeat (5) @(negedge clk);
    check({tag, " ready_count"}, ready_cnt - r0, 1);
  endtask

  // First measurement is re-armed during holdoff by measure at cycles p1/p2
  // after ready; a mid-MEASURE request is also issued and must be ignored.
  task automatic rearm_seq(input string tag, input int p1, input int p2);
    int lat;
    int c;
    int r0;
    r0 = ready_cnt;
    predict(24);
    predict(48);
    measure = 1'b1;
    @(negedge clk);
    measure = 1'b0;
    wait_trig(tag, lat);
    fork
      drive_echo(3, 24, 1'b1);
      wait_ready(tag, lat);
    join
    c = 0;
    do begin
      @(negedge clk);
      c++;
      measure = (c == p1) || (c == p2);
    end while (!trig && c < 200);
    measure = 1'b0;
    check({tag, " rearm_trig_lat"}, c, HOLDOFF_CYCLES + 1);
    wait_trig({tag, "2"}, lat);
    fork
      drive_echo(2, 48, 1'b0);
      begin
        int rl;
        wait_ready({tag, "2"}, rl);
        check_holdoff({tag, "2"});
      end
    join
    repeat (5) @(negedge clk);
    check({tag, " ready_count"}, ready_cnt - r0, 2);
  endtask

  initial begin
    int r0;
    rst_n   = 1'b0;
    measure = 1'b0;
    echo    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset trig", trig, 0);
    check("reset ready", ready, 0);
    check("reset distance", distance, 0);
    check("reset busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    measure_once("echo40", 5, 40);
    measure_once("no_echo", 0, 0);
    measure_once("stuck", 4, 2000);
    rearm_seq("pend", 3, 10);
    rearm_seq("term", HOLDOFF_CYCLES, 0);

    // Reset during TRIG
    r0 = ready_cnt;
    measure = 1'b1;
    @(negedge clk);
    measure = 1'b0;
    @(negedge clk);
    check("rst trig_before", trig, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst trig_async", trig, 0);
    check("rst busy", busy, 0);
    check("rst distance", distance, 0);
    exp_q.delete();
    model_dist  = 8'h00;
    model_first = 1'b1;
    last_exp    = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    check("rst no_ready", ready_cnt - r0, 0);

    measure_once("post_rst_a", 6, 40);
    measure_once("post_rst_b", 10, 84);
    measure_once("post_rst_to", 0, 0);

    for (int i = 0; i < 8; i++) begin
      int w;
      w = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 1150));
      measure_once($sformatf("rnd%0d", i), $urandom_range(0, 60), w);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
